// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   op_e    : RV32M funct3 operation encoding
//   state_e : control FSM states
// Helper functions classify an op by operand signedness and whether it divides.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL low word is sign-agnostic, so it is handled as unsigned
    function automatic logic op_a_signed(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Magnitudes are processed (shift-add multiply, restoring divide) and the
// sign is applied when leaving CALC. Divide-by-zero and signed overflow
// bypass CALC and finish one cycle after accept.
// Optional macro MULDIV_EARLY_OUT_EN: multiply with a zero operand also
// bypasses CALC and returns 0.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake (op, a, b latched on accept)
//   op[2:0], a, b         funct3 and operands
//   out_valid/out_ready   result handshake
//   result, div_by_zero   result word and divide-by-zero qualifier
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned W2 = 2 * XLEN;

    state_e          r_state, w_state_nxt;
    op_e             r_op;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_opd, r_result;
    logic            r_neg, r_dbz, r_in_ready, r_out_valid;

    op_e             w_op;
    logic            w_a_neg, w_b_neg, w_neg, w_div_zero, w_ovf, w_mul_zero;
    logic            w_special, w_last;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;
    logic [XLEN:0]   w_sum, w_rem_sh, w_diff;
    logic [XLEN-1:0] w_hi_n, w_lo_n, w_final;
    logic [W2-1:0]   w_prod;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign div_by_zero = r_dbz;

    // Request decode: magnitudes, result sign and bypass cases
    always_comb begin
        w_op       = op_e'(op);
        w_a_neg    = op_a_signed(w_op) && a[XLEN-1];
        w_b_neg    = op_b_signed(w_op) && b[XLEN-1];
        w_a_mag    = w_a_neg ? (~a + XLEN'(1)) : a;
        w_b_mag    = w_b_neg ? (~b + XLEN'(1)) : b;
        // Remainder follows the dividend; quotient/product follow a^b
        w_neg      = op_is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = op_is_div(w_op) && (b == '0);
        w_ovf      = (w_op == OP_DIV || w_op == OP_REM) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        w_mul_zero = !op_is_div(w_op) && ((a == '0) || (b == '0));
`else
        w_mul_zero = 1'b0;
`endif
        w_special  = w_div_zero || w_ovf || w_mul_zero;
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : a;
        end else if (w_ovf) begin
            w_special_res = (w_op == OP_DIV) ? a : '0;
        end
    end

    // One iteration step; r_opd is the multiplicand or the divisor
    always_comb begin
        w_sum    = {1'b0, r_hi} + {1'b0, r_opd};
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_opd};
        if (op_is_div(r_op)) begin
            w_hi_n = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else if (r_lo[0]) begin
            {w_hi_n, w_lo_n} = {w_sum, r_lo[XLEN-1:1]};
        end else begin
            {w_hi_n, w_lo_n} = {1'b0, r_hi, r_lo[XLEN-1:1]};
        end
        w_last = (r_cnt == CW'(XLEN - 1));
    end

    // Sign correction and word select on CALC exit
    always_comb begin
        w_prod  = {w_hi_n, w_lo_n};
        if (r_neg) begin
            w_prod = ~w_prod + W2'(1);
        end
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[W2-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = r_neg ? (~w_lo_n + XLEN'(1)) : w_lo_n;
            default:                      w_final = r_neg ? (~w_hi_n + XLEN'(1)) : w_hi_n;
        endcase
    end

    // State register with registered handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in CALC, capture result on exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op  <= w_op;
                        r_neg <= w_neg;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        r_lo  <= op_is_div(w_op) ? w_a_mag : w_b_mag;
                        r_opd <= op_is_div(w_op) ? w_b_mag : w_a_mag;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_dbz    <= w_div_zero;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_final;
                        r_dbz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
// Honours MULDIV_EARLY_OUT_EN for the zero-operand multiply latency.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE, measure latency, check and consume result
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_r,
                         input logic exp_z, input int exp_lat);
        int   lat;
        logic rdy_bad;
        check_eq({tag, "_inrdy"}, 64'(in_ready), 64'd1);
        op = f3; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy"}, 64'(rdy_bad), 64'd0);
        check_eq({tag, "_res"}, 64'(result), 64'(exp_r));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_z));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_r;
        logic        exp_z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int zlat;
`ifdef MULDIV_EARLY_OUT_EN
        zlat = 1;
`else
        zlat = 33;
`endif
        vecs.push_back('{"mul5x3",    3'b000, 32'd5,        32'd3,        32'h0000000F, 1'b0, 33});
        vecs.push_back('{"mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33});
        vecs.push_back('{"mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{"mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33});
        vecs.push_back('{"mulh_neg",  3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{"mul_neg",   3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0, 33});
        vecs.push_back('{"div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{"rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{"div_7_m2",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{"rem_7_m2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 33});
        vecs.push_back('{"divu_100",  3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 33});
        vecs.push_back('{"remu_100",  3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 33});
        vecs.push_back('{"divu_max",  3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{"divu_z",    3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{"remu_z",    3'b111, 32'd100,      32'd0,        32'd100,      1'b1, 1});
        vecs.push_back('{"div_z",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{"rem_z",     3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, 1});
        vecs.push_back('{"div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1});
        vecs.push_back('{"rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1});
        vecs.push_back('{"mul_zero",  3'b000, 32'd0,        32'd7,        32'h00000000, 1'b0, zlat});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_inrdy", 64'(in_ready), 64'd1);
        check_eq("rst_oval", 64'(out_valid), 64'd0);
        check_eq("rst_res", 64'(result), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].tag, vecs[i].f3, vecs[i].va, vecs[i].vb,
                  vecs[i].exp_r, vecs[i].exp_z, vecs[i].lat);
        end

        // Back-pressure in DONE: result held, new requests ignored
        begin
            int lat;
            op = 3'b000; a = 32'd5; b = 32'd3; in_valid = 1'b1;
            @(posedge clk); #1;
            lat = 1;
            // Present a divide-by-zero request that must not be taken
            op = 3'b101; a = 32'd9; b = 32'd0;
            while (!out_valid && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            check_eq("stall_lat", 64'(lat), 64'd33);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check_eq("stall_res", 64'(result), 64'h0000000F);
                check_eq("stall_flags", 64'({in_ready, out_valid}), 64'(2'b01));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_eq("stall_idle", 64'({in_ready, out_valid}), 64'(2'b10));
            check_eq("stall_keep", 64'(result), 64'h0000000F);
        end

        // Reset in the middle of CALC discards the operation
        begin
            logic saw_valid;
            op = 3'b000; a = 32'd6; b = 32'd7; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check_eq("mid_busy", 64'(in_ready), 64'd0);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check_eq("mid_inrdy", 64'(in_ready), 64'd1);
            check_eq("mid_oval", 64'(out_valid), 64'd0);
            check_eq("mid_res", 64'(result), 64'd0);
            saw_valid = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (out_valid) saw_valid = 1'b1;
            end
            check_eq("mid_noresult", 64'(saw_valid), 64'd0);
        end

        do_op("post_rst", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 33);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
